// File: rtl/mem_wb_stage_if.sv
// MEM->WB boundary bundle: MEM-stage result sources in, registered writeback state out.
// Master drives the MEM side; slave is the WB stage register.
interface mem_wb_stage_if #(
  parameter int DATA_W = 32,
  parameter int RD_W   = 5,
  parameter int CNT_W  = 32
);
  logic [1:0]        MEM_out_selector;
  logic [DATA_W-1:0] MEM_pc;
  logic [DATA_W-1:0] MEM_alu_out;
  logic [DATA_W-1:0] MEM_dmem_out;
  logic [1:0]        MEM_load_size;
  logic              MEM_load_signed;
  logic [RD_W-1:0]   MEM_rd;
  logic              MEM_rf_le;
  logic              MEM_valid;
  logic              WB_stall;
  logic              WB_flush;
  logic [DATA_W-1:0] WB_data;
  logic [RD_W-1:0]   WB_rd;
  logic              WB_rf_le;
  logic              WB_valid;
  logic [CNT_W-1:0]  WB_retire_count;
  logic              WB_misaligned;

  modport master (
    output MEM_out_selector, MEM_pc, MEM_alu_out, MEM_dmem_out, MEM_load_size,
           MEM_load_signed, MEM_rd, MEM_rf_le, MEM_valid, WB_stall, WB_flush,
    input  WB_data, WB_rd, WB_rf_le, WB_valid, WB_retire_count, WB_misaligned
  );

  modport slave (
    input  MEM_out_selector, MEM_pc, MEM_alu_out, MEM_dmem_out, MEM_load_size,
           MEM_load_signed, MEM_rd, MEM_rf_le, MEM_valid, WB_stall, WB_flush,
    output WB_data, WB_rd, WB_rf_le, WB_valid, WB_retire_count, WB_misaligned
  );
endinterface

// File: rtl/mem_wb_stage.sv
// SPARC MEM->WB pipeline register: result select, big-endian load alignment, retire counter.
// Optional misaligned-load detection is enabled by defining MEM_WB_MISALIGN_CHECK_EN.
module mem_wb_stage #(
  parameter int DATA_W = 32,
  parameter int RD_W   = 5,
  parameter int CNT_W  = 32
) (
  input logic           clk,
  input logic           reset,
  mem_wb_stage_if.slave bus
);

  logic [7:0]        lane [4];
  logic [1:0]        offset;
  logic [7:0]        byte_sel;
  logic [15:0]       half_sel;
  logic [DATA_W-1:0] load_data;
  logic [DATA_W-1:0] result_next;
  logic              capture_le_next;

  logic [DATA_W-1:0] data_reg;
  logic [RD_W-1:0]   rd_reg;
  logic              rf_le_reg;
  logic              valid_reg;
  logic [CNT_W-1:0]  count_reg;

  assign offset = bus.MEM_alu_out[1:0];

  // Lane 0 is the most significant byte (lowest address, big-endian).
  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_lane
      assign lane[gi] = bus.MEM_dmem_out[DATA_W-1-8*gi -: 8];
    end
  endgenerate

  always_comb begin
    byte_sel = lane[offset];
    half_sel = offset[1] ? bus.MEM_dmem_out[15:0] : bus.MEM_dmem_out[31:16];
    case (bus.MEM_load_size)
      2'b00:   load_data = {{24{bus.MEM_load_signed & byte_sel[7]}}, byte_sel};
      2'b01:   load_data = {{16{bus.MEM_load_signed & half_sel[15]}}, half_sel};
      default: load_data = bus.MEM_dmem_out;
    endcase
  end

  always_comb begin
    case (bus.MEM_out_selector)
      2'b10:   result_next = bus.MEM_alu_out;
      2'b11:   result_next = load_data;
      default: result_next = bus.MEM_pc;
    endcase
  end

`ifdef MEM_WB_MISALIGN_CHECK_EN
  logic misaligned_next;
  logic misaligned_reg;

  always_comb begin
    misaligned_next = 1'b0;
    if (bus.MEM_out_selector == 2'b11) begin
      if (bus.MEM_load_size == 2'b01)
        misaligned_next = offset[0];
      else if (bus.MEM_load_size[1])
        misaligned_next = (offset != 2'b00);
    end
  end

  assign capture_le_next = bus.MEM_rf_le & bus.MEM_valid & ~misaligned_next;

  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      misaligned_reg <= 1'b0;
    else if (bus.WB_flush)
      misaligned_reg <= 1'b0;
    else if (!bus.WB_stall)
      misaligned_reg <= misaligned_next;
  end

  assign bus.WB_misaligned = misaligned_reg;
`else
  assign capture_le_next   = bus.MEM_rf_le & bus.MEM_valid;
  assign bus.WB_misaligned = 1'b0;
`endif

  // Flush only kills valid/rf_le; data and rd are don't-care and simply hold.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      data_reg  <= '0;
      rd_reg    <= '0;
      rf_le_reg <= 1'b0;
      valid_reg <= 1'b0;
      count_reg <= '0;
    end else if (bus.WB_flush) begin
      rf_le_reg <= 1'b0;
      valid_reg <= 1'b0;
    end else if (!bus.WB_stall) begin
      data_reg  <= result_next;
      rd_reg    <= bus.MEM_rd;
      rf_le_reg <= capture_le_next;
      valid_reg <= bus.MEM_valid;
      if (bus.MEM_valid)
        count_reg <= count_reg + CNT_W'(1);
    end
  end

  assign bus.WB_data         = data_reg;
  assign bus.WB_rd           = rd_reg;
  assign bus.WB_rf_le        = rf_le_reg;
  assign bus.WB_valid        = valid_reg;
  assign bus.WB_retire_count = count_reg;

endmodule

// File: tb/tb_mem_wb_stage.sv
// Self-checking bench for mem_wb_stage: directed vector table, stall/flush/reset sequences,
// counter wrap with a 4-bit counter, and random traffic against a behavioural model.
module tb_mem_wb_stage;

  localparam int CNT_W = 4;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  mem_wb_stage_if #(.DATA_W(32), .RD_W(5), .CNT_W(CNT_W)) bus ();

  mem_wb_stage #(.DATA_W(32), .RD_W(5), .CNT_W(CNT_W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int checks = 0;
  int failures = 0;

  // Behavioural model state
  logic [31:0] m_data;
  logic [4:0]  m_rd;
  logic        m_rf_le, m_valid, m_mis;
  int unsigned m_cnt;

  typedef struct {
    logic [1:0]  sel;
    logic [31:0] pc, alu, dmem;
    logic [1:0]  size;
    logic        sgn;
    logic [4:0]  rd;
    logic [31:0] exp_data;
  } vec_t;

  function automatic logic [31:0] ref_result(logic [1:0] sel, logic [31:0] pc, logic [31:0] alu,
                                             logic [31:0] dmem, logic [1:0] size, logic sgn);
    int unsigned off, v;
    off = alu & 32'd3;
    if (sel < 2) return pc;
    if (sel == 2) return alu;
    if (size == 0) begin
      v = (dmem >> (24 - 8 * off)) & 32'hFF;
      if (sgn && v >= 128) v = v + 32'hFFFF_FF00;
      return v;
    end
    if (size == 1) begin
      v = (off >= 2) ? (dmem & 32'hFFFF) : (dmem >> 16);
      if (sgn && v >= 32768) v = v + 32'hFFFF_0000;
      return v;
    end
    return dmem;
  endfunction

  function automatic logic ref_misaligned(logic [1:0] sel, logic [31:0] alu, logic [1:0] size);
`ifdef MEM_WB_MISALIGN_CHECK_EN
    int unsigned off;
    off = alu % 4;
    if (sel != 3) return 1'b0;
    if (size == 1) return (off % 2) == 1;
    if (size >= 2) return off != 0;
    return 1'b0;
`else
    return 1'b0;
`endif
  endfunction

  task automatic model_reset();
    m_data = 0; m_rd = 0; m_rf_le = 0; m_valid = 0; m_mis = 0; m_cnt = 0;
  endtask

  // Apply the rules for one rising edge using the stimulus currently driven.
  task automatic model_edge();
    logic mis;
    if (bus.WB_flush) begin
      m_valid = 0; m_rf_le = 0; m_mis = 0;
    end else if (!bus.WB_stall) begin
      mis     = ref_misaligned(bus.MEM_out_selector, bus.MEM_alu_out, bus.MEM_load_size);
      m_data  = ref_result(bus.MEM_out_selector, bus.MEM_pc, bus.MEM_alu_out,
                           bus.MEM_dmem_out, bus.MEM_load_size, bus.MEM_load_signed);
      m_rd    = bus.MEM_rd;
      m_valid = bus.MEM_valid;
      m_rf_le = bus.MEM_rf_le && bus.MEM_valid && !mis;
      m_mis   = mis;
      if (bus.MEM_valid) m_cnt = (m_cnt + 1) % (1 << CNT_W);
    end
  endtask

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic check_all(string tag);
    chk({tag, ".data"},  bus.WB_data, m_data);
    chk({tag, ".rd"},    {27'd0, bus.WB_rd}, {27'd0, m_rd});
    chk({tag, ".rf_le"}, {31'd0, bus.WB_rf_le}, {31'd0, m_rf_le});
    chk({tag, ".valid"}, {31'd0, bus.WB_valid}, {31'd0, m_valid});
    chk({tag, ".count"}, {28'd0, bus.WB_retire_count}, m_cnt);
    chk({tag, ".mis"},   {31'd0, bus.WB_misaligned}, {31'd0, m_mis});
  endtask

  task automatic drive(logic [1:0] sel, logic [31:0] pc, logic [31:0] alu, logic [31:0] dmem,
                       logic [1:0] size, logic sgn, logic [4:0] rd, logic rf_le, logic valid,
                       logic stall, logic flush);
    bus.MEM_out_selector = sel;  bus.MEM_pc = pc;        bus.MEM_alu_out = alu;
    bus.MEM_dmem_out     = dmem; bus.MEM_load_size = size; bus.MEM_load_signed = sgn;
    bus.MEM_rd = rd; bus.MEM_rf_le = rf_le; bus.MEM_valid = valid;
    bus.WB_stall = stall; bus.WB_flush = flush;
  endtask

  task automatic step();
    model_edge();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    model_reset();
    #1;
    check_all("reset");
    @(negedge clk);
    reset = 1'b0;
  endtask

  vec_t vecs [7];

  initial begin
    vecs[0] = '{2'b01, 32'h0000_0040, 32'h0,          32'h0,          2'b10, 1'b0, 5'd1, 32'h0000_0040};
    vecs[1] = '{2'b10, 32'h0000_0044, 32'h1234_5678,  32'h0,          2'b10, 1'b0, 5'd2, 32'h1234_5678};
    vecs[2] = '{2'b00, 32'hDEAD_BEEC, 32'h5555_5555,  32'h0,          2'b10, 1'b0, 5'd3, 32'hDEAD_BEEC};
    vecs[3] = '{2'b11, 32'h0,         32'h0000_0100,  32'h80FF_7F01,  2'b00, 1'b1, 5'd4, 32'hFFFF_FF80};
    vecs[4] = '{2'b11, 32'h0,         32'h0000_0101,  32'h80FF_7F01,  2'b00, 1'b0, 5'd5, 32'h0000_00FF};
    vecs[5] = '{2'b11, 32'h0,         32'h0000_0102,  32'h80FF_7F01,  2'b01, 1'b1, 5'd6, 32'h0000_7F01};
    vecs[6] = '{2'b11, 32'h0,         32'h0000_0104,  32'h80FF_7F01,  2'b10, 1'b1, 5'd7, 32'h80FF_7F01};

    drive(2'b00, 0, 0, 0, 2'b00, 0, 0, 0, 0, 0, 0);
    do_reset();

    // Directed vector table
    for (int i = 0; i < 7; i++) begin
      drive(vecs[i].sel, vecs[i].pc, vecs[i].alu, vecs[i].dmem, vecs[i].size, vecs[i].sgn,
            vecs[i].rd, 1'b1, 1'b1, 1'b0, 1'b0);
      step();
      chk($sformatf("vec%0d.table", i), bus.WB_data, vecs[i].exp_data);
      check_all($sformatf("vec%0d", i));
      $display("vec %0d sel=%0d data=0x%08h count=%0d", i, vecs[i].sel, bus.WB_data, bus.WB_retire_count);
    end

    // Stall holds everything, then stall+flush squashes without counting
    drive(2'b10, 0, 32'hCAFE_0005, 0, 2'b10, 0, 5'd5, 1'b1, 1'b1, 1'b0, 1'b0);
    step();
    check_all("cap_rd5");
    for (int i = 0; i < 3; i++) begin
      drive(2'b10, 0, 32'h1111_0000 + i, 0, 2'b10, 0, 5'd9, 1'b0, 1'b1, 1'b1, 1'b0);
      step();
      chk($sformatf("stall%0d.rd", i), {27'd0, bus.WB_rd}, 32'd5);
      chk($sformatf("stall%0d.data", i), bus.WB_data, 32'hCAFE_0005);
      check_all($sformatf("stall%0d", i));
      $display("stall %0d rd=%0d count=%0d", i, bus.WB_rd, bus.WB_retire_count);
    end
    drive(2'b10, 0, 32'h2222_2222, 0, 2'b10, 0, 5'd9, 1'b1, 1'b1, 1'b1, 1'b1);
    step();
    chk("flush.valid", {31'd0, bus.WB_valid}, 32'd0);
    chk("flush.rf_le", {31'd0, bus.WB_rf_le}, 32'd0);
    check_all("flush");
    $display("stall+flush valid=%0d count=%0d", bus.WB_valid, bus.WB_retire_count);

    // Counter wrap: 17 valid retires interleaved with bubbles on a 4-bit counter
    do_reset();
    for (int i = 0; i < 17; i++) begin
      drive(2'b00, i, 0, 0, 2'b10, 0, 5'd1, 1'b1, 1'b1, 1'b0, 1'b0);
      step();
      drive(2'b00, i, 0, 0, 2'b10, 0, 5'd1, 1'b1, 1'b0, 1'b0, 1'b0);
      step();
    end
    chk("wrap.count", {28'd0, bus.WB_retire_count}, 32'd1);
    check_all("wrap");
    $display("wrap count=%0d", bus.WB_retire_count);

`ifdef MEM_WB_MISALIGN_CHECK_EN
    drive(2'b11, 0, 32'h0000_0202, 32'h1234_5678, 2'b10, 0, 5'd8, 1'b1, 1'b1, 1'b0, 1'b0);
    step();
    chk("mis.flag", {31'd0, bus.WB_misaligned}, 32'd1);
    chk("mis.rf_le", {31'd0, bus.WB_rf_le}, 32'd0);
    check_all("mis");
    drive(2'b11, 0, 32'h0000_0204, 32'h1234_5678, 2'b10, 0, 5'd8, 1'b1, 1'b1, 1'b0, 1'b0);
    step();
    chk("mis_clr.flag", {31'd0, bus.WB_misaligned}, 32'd0);
    chk("mis_clr.rf_le", {31'd0, bus.WB_rf_le}, 32'd1);
    check_all("mis_clr");
    $display("misalign flag=%0d then clear", 1);
`endif

    // Randomized traffic against the model
    for (int i = 0; i < 300; i++) begin
      drive(2'($urandom), $urandom, $urandom, $urandom, 2'($urandom), 1'($urandom),
            5'($urandom), 1'($urandom), ($urandom_range(0, 3) != 0),
            ($urandom_range(0, 4) == 0), ($urandom_range(0, 9) == 0));
      step();
      check_all($sformatf("rand%0d", i));
      $display("rand %0d sel=%0d stall=%0d flush=%0d data=0x%08h count=%0d", i,
               bus.MEM_out_selector, bus.WB_stall, bus.WB_flush, bus.WB_data, bus.WB_retire_count);
    end

    // Asynchronous reset mid-stream with valid output and count 7
    do_reset();
    for (int i = 0; i < 7; i++) begin
      drive(2'b10, 0, 32'hA0 + i, 0, 2'b10, 0, 5'd3, 1'b1, 1'b1, 1'b0, 1'b0);
      step();
    end
    chk("pre_areset.count", {28'd0, bus.WB_retire_count}, 32'd7);
    chk("pre_areset.valid", {31'd0, bus.WB_valid}, 32'd1);
    #2;
    reset = 1'b1;
    model_reset();
    #1;
    check_all("areset");
    chk("areset.count", {28'd0, bus.WB_retire_count}, 32'd0);
    $display("async reset valid=%0d count=%0d", bus.WB_valid, bus.WB_retire_count);
    #1;
    reset = 1'b0;
    drive(2'b01, 32'h0000_0777, 0, 0, 2'b10, 0, 5'd2, 1'b1, 1'b1, 1'b0, 1'b0);
    step();
    check_all("post_reset");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
